player_ctrl: RTL

//  Per-player motion/animation sequencer driving the sprite renderer's playerX/playerY/sprite_num.
//  On each frame tick: sample the direction buttons, propose a new position to the map collision

---
 rtl/player_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/player_ctrl.sv
// Per-player motion/animation sequencer: samples buttons on frame ticks, negotiates moves with the
// map collision checker over a valid/ack handshake, and sequences death and respawn.
module player_ctrl #(
  parameter int unsigned SPAWN_X    = 32,
  parameter int unsigned SPAWN_Y    = 32,
  parameter int unsigned STEP       = 2,
  parameter int unsigned X_MIN      = 32,
  parameter int unsigned X_MAX      = 576,
  parameter int unsigned Y_MIN      = 32,
  parameter int unsigned Y_MAX      = 416,
  parameter int unsigned ANIM_DIV   = 8,
  parameter int unsigned DIE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       hit,
  input  logic       respawn,
  output logic       cand_valid,
  output logic [9:0] cand_x,
  output logic [9:0] cand_y,
  input  logic       cand_ack,
  input  logic       cand_free,
  output logic [9:0] playerX,
  output logic [9:0] playerY,
  output logic [2:0] sprite_num,
  output logic       alive
);

  localparam int unsigned AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int unsigned DW = (DIE_FRAMES > 1) ? $clog2(DIE_FRAMES) : 1;

  // Saturation thresholds precomputed so the clamp never leaves 10-bit range.
  localparam logic [9:0] X_LO   = 10'(X_MIN);
  localparam logic [9:0] X_HI   = 10'(X_MAX - 32);
  localparam logic [9:0] Y_LO   = 10'(Y_MIN);
  localparam logic [9:0] Y_HI   = 10'(Y_MAX - 32);
  localparam logic [9:0] X_LO_S = 10'(X_MIN + STEP);
  localparam logic [9:0] X_HI_S = 10'(X_MAX - 32 - STEP);
  localparam logic [9:0] Y_LO_S = 10'(Y_MIN + STEP);
  localparam logic [9:0] Y_HI_S = 10'(Y_MAX - 32 - STEP);
  localparam logic [9:0] STP    = 10'(STEP);
  localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_DIV - 1);
  localparam logic [DW-1:0] DIE_LAST  = DW'(DIE_FRAMES - 1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DYING, S_DEAD} state_t;
  typedef enum logic [1:0] {DIR_DOWN, DIR_UP, DIR_LEFT, DIR_RIGHT} dir_t;

  state_t          state_q, state_d;
  dir_t            dir_q, dir_d, btn_dir;
  logic            btn_any;
  logic [9:0]      x_q, x_d, y_q, y_d, cx_q, cx_d, cy_q, cy_d, nx, ny;
  logic            cv_q, cv_d, phase_q, phase_d;
  logic [AW-1:0]   anim_q, anim_d;
  logic [DW-1:0]   die_q, die_d;

  always_comb begin
    btn_any = btn_up | btn_down | btn_left | btn_right;
    btn_dir = dir_q;
    if (btn_up)         btn_dir = DIR_UP;
    else if (btn_down)  btn_dir = DIR_DOWN;
    else if (btn_left)  btn_dir = DIR_LEFT;
    else if (btn_right) btn_dir = DIR_RIGHT;
    nx = x_q;
    ny = y_q;
    case (btn_dir)
      DIR_UP:    ny = (y_q >= Y_LO_S) ? y_q - STP : Y_LO;
      DIR_DOWN:  ny = (y_q <= Y_HI_S) ? y_q + STP : Y_HI;
      DIR_LEFT:  nx = (x_q >= X_LO_S) ? x_q - STP : X_LO;
      DIR_RIGHT: nx = (x_q <= X_HI_S) ? x_q + STP : X_HI;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    x_d     = x_q;
    y_d     = y_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    cv_d    = cv_q;
    phase_d = phase_q;
    anim_d  = anim_q;
    die_d   = die_q;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          state_d = S_DYING;
          cv_d    = 1'b0;
          die_d   = '0;
        end else if (frame_tick) begin
          if (!btn_any) begin
            phase_d = 1'b0;
            anim_d  = '0;
          end else begin
            dir_d = btn_dir;
            // Animation advances on the held button even if the move ends up refused.
            if (anim_q == ANIM_LAST) begin
              anim_d  = '0;
              phase_d = ~phase_q;
            end else begin
              anim_d = anim_q + AW'(1);
            end
            if (nx != x_q || ny != y_q) begin
              cx_d    = nx;
              cy_d    = ny;
              cv_d    = 1'b1;
              state_d = S_CHECK;
            end
          end
        end
      end
      S_CHECK: begin
        if (hit) begin
          state_d = S_DYING;
          cv_d    = 1'b0;
          die_d   = '0;
        end else if (cand_ack) begin
          cv_d    = 1'b0;
          state_d = S_IDLE;
          if (cand_free) begin
            x_d = cx_q;
            y_d = cy_q;
          end
        end
      end
      S_DYING: begin
        if (frame_tick) begin
          if (die_q == DIE_LAST) state_d = S_DEAD;
          else                   die_d   = die_q + DW'(1);
        end
      end
      S_DEAD: begin
        if (respawn) begin
          state_d = S_IDLE;
          x_d     = 10'(SPAWN_X);
          y_d     = 10'(SPAWN_Y);
          dir_d   = DIR_DOWN;
          phase_d = 1'b0;
          anim_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      dir_q   <= DIR_DOWN;
      x_q     <= 10'(SPAWN_X);
      y_q     <= 10'(SPAWN_Y);
      cx_q    <= '0;
      cy_q    <= '0;
      cv_q    <= 1'b0;
      phase_q <= 1'b0;
      anim_q  <= '0;
      die_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      cv_q    <= cv_d;
      phase_q <= phase_d;
      anim_q  <= anim_d;
      die_q   <= die_d;
    end
  end

  always_comb begin
    sprite_num = 3'd6;
    if (state_q == S_IDLE || state_q == S_CHECK) begin
      case (dir_q)
        DIR_DOWN: sprite_num = {2'b00, phase_q};
        DIR_UP:   sprite_num = {2'b01, phase_q};
        DIR_LEFT: sprite_num = 3'd4;
        default:  sprite_num = 3'd5;
      endcase
    end
  end

  assign alive      = (state_q == S_IDLE) || (state_q == S_CHECK);
  assign cand_valid = cv_q;
  assign cand_x     = cx_q;
  assign cand_y     = cy_q;
  assign playerX    = x_q;
  assign playerY    = y_q;

endmodule
